// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } state_e;

  localparam int CNT_WIDTH              = 16;
  localparam int DEFAULT_GAP_CYCLES     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches upward from the requester
// after the last grant, wrapping around.
module rr_arbiter #(
  parameter int G_NB_REQ = 2
) (
  input  logic [G_NB_REQ-1:0]         i_req,
  input  logic [$clog2(G_NB_REQ)-1:0] i_last,
  output logic [$clog2(G_NB_REQ)-1:0] o_grant,
  output logic                        o_valid
);

  localparam int IW = $clog2(G_NB_REQ);

  int idx;

  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    o_grant = '0;
    o_valid = 1'b0;
    idx     = 0;
    for (int off = 1; off <= G_NB_REQ; off++) begin
      idx = (int'(i_last) + off) % G_NB_REQ;
      if (!o_valid && i_req[IW'(idx)]) begin
        o_valid = 1'b1;
        o_grant = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding one UART transmitter: captures a requester's
// payload, starts the frame, waits for done (with timeout), then idles a gap.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int G_NB_REQ         = 2,
  parameter int G_DATA_WIDTH     = 8,
  parameter int G_GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int G_TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [G_NB_REQ-1:0]              i_req,
  input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_data,
  output logic [G_NB_REQ-1:0]              o_ack,
  output logic                             o_tx_start,
  output logic [G_DATA_WIDTH-1:0]          o_tx_data,
  input  logic                             i_tx_done,
  output logic [$clog2(G_NB_REQ)-1:0]      o_grant_id,
  output logic                             o_busy,
  output logic                             o_timeout_err
);

  localparam int                   IW           = $clog2(G_NB_REQ);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(G_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST     = CNT_WIDTH'(G_GAP_CYCLES - 1);
  localparam logic [IW-1:0]        LAST_RESET   = IW'(G_NB_REQ - 1);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]           last_q, last_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [G_NB_REQ-1:0]     ack_q, ack_d;
  logic [G_DATA_WIDTH-1:0] data_q, data_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic [IW-1:0]           arb_grant;
  logic                    arb_valid;
  logic [G_DATA_WIDTH-1:0] data_lane [G_NB_REQ];

  rr_arbiter #(.G_NB_REQ(G_NB_REQ)) u_arb (
    .i_req   (i_req),
    .i_last  (last_q),
    .o_grant (arb_grant),
    .o_valid (arb_valid)
  );

  for (genvar k = 0; k < G_NB_REQ; k++) begin : g_lane
    assign data_lane[k] = i_data[k*G_DATA_WIDTH +: G_DATA_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    start_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          ack_d   = G_NB_REQ'(1) << arb_grant;
          grant_d = arb_grant;
          last_d  = arb_grant;
          data_d  = data_lane[arb_grant];
          state_d = ST_START;
        end
      end
      ST_START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A done arriving on the expiry cycle wins over the timeout.
        if (i_tx_done) begin
          cnt_d   = '0;
          state_d = (G_GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RESET;
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_ack         = ack_q;
  assign o_tx_start    = start_q;
  assign o_tx_data     = data_q;
  assign o_grant_id    = grant_q;
  assign o_busy        = busy_q;
  assign o_timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a timestamp-based reference model predicts every
// output each cycle, under directed scenarios followed by random traffic.
module tb_uart_tx_scheduler;

  localparam int NB  = 2;
  localparam int W   = 8;
  localparam int GAP = 4;
  localparam int TO  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NB-1:0]           i_req;
  logic [NB*W-1:0]         i_data;
  logic [NB-1:0]           o_ack;
  logic                    o_tx_start;
  logic [W-1:0]            o_tx_data;
  logic                    i_tx_done;
  logic [$clog2(NB)-1:0]   o_grant_id;
  logic                    o_busy;
  logic                    o_timeout_err;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .G_NB_REQ         (NB),
    .G_DATA_WIDTH     (W),
    .G_GAP_CYCLES     (GAP),
    .G_TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (i_req),
    .i_data        (i_data),
    .o_ack         (o_ack),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .i_tx_done     (i_tx_done),
    .o_grant_id    (o_grant_id),
    .o_busy        (o_busy),
    .o_timeout_err (o_timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int auto_done = -1;   // when >= 0, done is pulsed this many cycles after each start

  // Reference model: absolute cycle numbers of the predicted events.
  int            m_idle_from = 0;
  int            m_busy_lo   = 0;
  int            m_ack_cyc   = -1;
  int            m_start_cyc = -1000;
  int            m_err_cyc   = -1;
  int            m_win_lo    = -1;
  int            m_win_hi    = -2;
  int            m_last      = NB - 1;
  int            m_grant     = 0;
  logic [NB-1:0] m_ack_vec   = '0;
  logic [W-1:0]  m_data      = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic bit_of(input logic [NB-1:0] v, input int r);
    logic [NB-1:0] s;
    s = v >> r;
    return s[0];
  endfunction

  function automatic logic [NB*W-1:0] put_lane(input logic [NB*W-1:0] bus, input int r,
                                               input logic [W-1:0] v);
    logic [NB*W-1:0] lane;
    lane = (NB*W)'({W{1'b1}}) << (r*W);
    return (bus & ~lane) | ((NB*W)'(v) << (r*W));
  endfunction

  // Consume the inputs of the current cycle and schedule future output events.
  task automatic model_update();
    int w;
    int idx;
    logic [NB*W-1:0] dsh;
    if (rst) begin
      m_idle_from = cyc + 1;
      m_ack_cyc   = -1;
      m_start_cyc = -1000;
      m_err_cyc   = -1;
      m_win_lo    = -1;
      m_win_hi    = -2;
      m_last      = NB - 1;
      m_grant     = 0;
      m_data      = '0;
    end else if (cyc >= m_idle_from) begin
      if (i_req != '0) begin
        w = -1;
        for (int off = 1; off <= NB; off++) begin
          idx = (m_last + off) % NB;
          if (w < 0 && bit_of(i_req, idx)) w = idx;
        end
        dsh         = i_data >> (w*W);
        m_data      = dsh[W-1:0];
        m_last      = w;
        m_grant     = w;
        m_ack_vec   = NB'(1) << w;
        m_busy_lo   = cyc + 1;
        m_ack_cyc   = cyc + 1;
        m_start_cyc = cyc + 2;
        m_win_lo    = cyc + 2;
        m_win_hi    = cyc + 1 + TO;
        m_err_cyc   = cyc + 2 + TO;
        m_idle_from = cyc + 2 + TO;
      end
    end else if (i_tx_done && cyc >= m_win_lo && cyc <= m_win_hi) begin
      m_err_cyc   = -1;
      m_win_hi    = -2;
      m_idle_from = cyc + 1 + GAP;
    end
  endtask

  task automatic compare_outputs();
    check("ack",         32'(o_ack), (cyc == m_ack_cyc) ? 32'(m_ack_vec) : 32'd0);
    check("tx_start",    32'(o_tx_start),    32'(cyc == m_start_cyc));
    check("timeout_err", 32'(o_timeout_err), 32'(cyc == m_err_cyc));
    check("busy",        32'(o_busy),        32'(cyc >= m_busy_lo && cyc < m_idle_from));
    check("grant_id",    32'(o_grant_id),    32'(m_grant));
    check("tx_data",     32'(o_tx_data),     32'(m_data));
  endtask

  task automatic cycle();
    if (auto_done >= 0) i_tx_done = (cyc == m_start_cyc + auto_done);
    model_update();
    @(posedge clk);
    cyc++;
    #1;
    compare_outputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int e;
    int cnt;
    int st_cyc[$];
    int st_dat[$];

    rst = 1'b1; i_req = '0; i_data = '0; i_tx_done = 1'b0;
    repeat (3) cycle();
    check("rst_busy",  32'(o_busy),     32'd0);
    check("rst_gid",   32'(o_grant_id), 32'd0);
    check("rst_data",  32'(o_tx_data),  32'd0);
    check("rst_start", 32'(o_tx_start), 32'd0);
    rst = 1'b0;
    repeat (2) cycle();

    // Single request: ack next cycle, start the one after with captured data.
    i_req = 2'b01; i_data = {8'h00, 8'hA5}; auto_done = 3;
    cycle();
    check("single_ack", 32'(o_ack), 32'd1);
    i_req = '0;
    cycle();
    check("single_start", 32'(o_tx_start), 32'd1);
    check("single_data",  32'(o_tx_data),  32'hA5);
    check("single_gid",   32'(o_grant_id), 32'd0);
    repeat (12) cycle();
    check("single_idle", 32'(o_busy), 32'd0);

    // Contention from a fresh reset: frames alternate, fixed start spacing.
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    i_req = 2'b11; i_data = {8'h22, 8'h11}; auto_done = 10;
    for (int k = 0; k < 80 && st_cyc.size() < 3; k++) begin
      cycle();
      if (o_tx_start) begin
        st_cyc.push_back(cyc);
        st_dat.push_back(int'(o_tx_data));
      end
    end
    check("cont_frames", 32'(st_cyc.size()), 32'd3);
    while (st_cyc.size() < 3) begin
      st_cyc.push_back(0);
      st_dat.push_back(0);
    end
    check("cont_d0", st_dat[0], 32'h11);
    check("cont_d1", st_dat[1], 32'h22);
    check("cont_d2", st_dat[2], 32'h11);
    check("cont_spacing01", st_cyc[1] - st_cyc[0], 32'd17);
    check("cont_spacing12", st_cyc[2] - st_cyc[1], 32'd17);
    i_req = '0;
    repeat (25) cycle();

    // Timeout: no done ever arrives.
    auto_done = -1; i_tx_done = 1'b0;
    i_req = 2'b01; i_data = {8'h00, 8'h5C};
    cycle(); i_req = '0;
    cycle(); s = cyc;
    check("to_start", 32'(o_tx_start), 32'd1);
    e = -1;
    for (int k = 0; k < 40 && e < 0; k++) begin
      cycle();
      if (o_timeout_err) begin
        e = cyc;
        check("to_busy_at_err", 32'(o_busy), 32'd0);
      end
    end
    check("to_latency", e - s, 32'd16);
    cycle();
    check("to_busy_after", 32'(o_busy),        32'd0);
    check("to_err_pulse",  32'(o_timeout_err), 32'd0);

    // Done on the last waiting cycle counts as done.
    auto_done = 15;
    i_req = 2'b01;
    cycle(); i_req = '0;
    cycle();
    cnt = 0;
    repeat (16) begin
      cycle();
      if (o_timeout_err) cnt++;
    end
    check("exp_no_err",   cnt,                0);
    check("exp_gap_busy", 32'(o_busy),        32'd1);
    repeat (6) cycle();
    check("exp_idle", 32'(o_busy), 32'd0);

    // Reset while waiting for done; both requesters pending afterwards.
    auto_done = -1; i_tx_done = 1'b0;
    i_req = 2'b01; i_data = {8'h77, 8'h66};
    cycle(); i_req = 2'b11;
    repeat (3) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rm_ack",   32'(o_ack),         32'd0);
    check("rm_start", 32'(o_tx_start),    32'd0);
    check("rm_err",   32'(o_timeout_err), 32'd0);
    check("rm_busy",  32'(o_busy),        32'd0);
    check("rm_gid",   32'(o_grant_id),    32'd0);
    check("rm_data",  32'(o_tx_data),     32'd0);
    cycle();
    check("rm_first_ack", 32'(o_ack),      32'd1);
    check("rm_first_gid", 32'(o_grant_id), 32'd0);
    i_req = '0; auto_done = 2;
    repeat (12) cycle();

    // A request raised and dropped entirely inside the gap is never served.
    i_req = 2'b01;
    cycle(); i_req = '0;
    for (int k = 0; k < 20 && cyc != m_start_cyc + 2; k++) cycle();
    cycle();
    check("wd_in_gap", 32'(o_busy), 32'd1);
    i_req = 2'b10; i_data = {8'h99, 8'h00};
    repeat (2) cycle();
    i_req = '0;
    cnt = 0;
    repeat (12) begin
      cycle();
      if (o_ack != '0) cnt++;
    end
    check("wd_no_ack", cnt,                0);
    check("wd_idle",   32'(o_busy), 32'd0);

    // Random traffic: requesters follow the hold-until-ack rule, done and
    // reset arrive at random, including outside the waiting window.
    auto_done = -1;
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 299) == 0);
      i_tx_done = ($urandom_range(0, 7) == 0);
      for (int r = 0; r < NB; r++) begin
        if (!bit_of(i_req, r)) begin
          if ($urandom_range(0, 3) == 0) begin
            i_req  = i_req | (NB'(1) << r);
            i_data = put_lane(i_data, r, W'($urandom));
          end
        end else if (cyc == m_ack_cyc && bit_of(m_ack_vec, r)) begin
          if ($urandom_range(0, 1) == 0) i_req = i_req & ~(NB'(1) << r);
          else                           i_data = put_lane(i_data, r, W'($urandom));
        end else if ($urandom_range(0, 29) == 0) begin
          i_req = i_req & ~(NB'(1) << r);
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter G_NB_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter G_DATA_WIDTH, default 8, UART frame payload width.
REQ-003 SHALL have parameter G_GAP_CYCLES, default 4, idle clk cycles between frames (0 allowed).
REQ-004 SHALL have parameter G_TIMEOUT_CYCLES, default 4096, max clk cycles waiting for tx done (>=2).
REQ-005 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_req  in  G_NB_REQ  per-requester transmit request, level.
REQ-008 SHALL have port i_data  in  G_NB_REQ*G_DATA_WIDTH  requester k payload at bits [k*W +: W].
REQ-009 SHALL have port o_ack  out  G_NB_REQ  one-cycle pulse, requester k payload captured.
REQ-010 SHALL have port o_tx_start  out  1  one-cycle start pulse to UART transmitter.
REQ-011 SHALL have port o_tx_data  out  G_DATA_WIDTH  captured payload, stable from o_tx_start until next capture.
REQ-012 SHALL have port i_tx_done  in  1  one-cycle pulse from transmitter, frame sent.
REQ-013 SHALL have port o_grant_id  out  clog2(G_NB_REQ)  index of requester currently served.
REQ-014 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port o_timeout_err  out  1  one-cycle pulse when the done-wait expires.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT_DONE, GAP.
REQ-017 IDLE: if any i_req bit high, SHALL select winner, register o_grant_id and o_tx_data, pulse o_ack[winner], go START on the next edge.
REQ-018 Arbitration SHALL be round-robin: search starts at (last grant + 1) mod G_NB_REQ; after reset last grant = G_NB_REQ-1, so requester 0 has first priority.
REQ-019 START: o_tx_start SHALL be high exactly one cycle, then go WAIT_DONE; latency i_req sampled at edge n -> o_ack high cycle n+1 -> o_tx_start high cycle n+2.
REQ-020 WAIT_DONE: on i_tx_done, go GAP if G_GAP_CYCLES>0, else IDLE.
REQ-021 WAIT_DONE: 16-bit cycle counter; when it reaches G_TIMEOUT_CYCLES-1 with no i_tx_done, SHALL pulse o_timeout_err one cycle and go IDLE.
REQ-022 i_tx_done coincident with timeout expiry SHALL count as done; no o_timeout_err.
REQ-023 i_tx_done outside WAIT_DONE SHALL be ignored.
REQ-024 GAP: SHALL stay exactly G_GAP_CYCLES cycles, then IDLE; requests are not evaluated during GAP.
REQ-025 Requester SHALL hold i_req and i_data until o_ack; i_req dropped before ack withdraws the request with no side effect.
REQ-026 i_req held high after o_ack SHALL be treated as a new request (back-to-back frames).
REQ-027 At most one o_ack bit SHALL be high in any cycle; o_ack and o_tx_start never high in the same cycle.
REQ-028 Last-grant pointer SHALL update only on o_ack, not on timeout.

Reset
REQ-029 With rst high at an edge: state IDLE, o_ack=0, o_tx_start=0, o_tx_data=0, o_grant_id=0, o_busy=0, o_timeout_err=0, counters=0, last grant=G_NB_REQ-1.
REQ-030 Reset mid-frame SHALL abort without pulse on any output; first request after rst release follows REQ-017.

Structure
REQ-031 Package uart_sched_pkg SHALL hold the state enum type, counter width constant (16), and default gap/timeout constants.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (combinational: req vector, last-grant pointer -> grant index, valid).

Verification
REQ-033 Single req: i_req=2'b01, i_data[7:0]=8'hA5 at edge n -> o_ack=01 cycle n+1, o_tx_start with o_tx_data=8'hA5 cycle n+2, o_grant_id=0.
REQ-034 Contention: both held, data 8'h11/8'h22, i_tx_done 10 cycles after each start -> frames alternate 8'h11,8'h22,8'h11; next start exactly 4 cycles (gap) after the done cycle plus 1-cycle IDLE/ack and START.
REQ-035 Timeout: G_TIMEOUT_CYCLES=16, no i_tx_done -> o_timeout_err pulse 16 cycles after WAIT_DONE entry, o_busy low next cycle.
REQ-036 Done at expiry cycle: i_tx_done on the 16th WAIT_DONE cycle -> no o_timeout_err, enters GAP.
REQ-037 Reset mid-frame: rst asserted in WAIT_DONE -> all outputs 0 next cycle; pending req 1 after release served with o_grant_id=0 first.
REQ-038 Withdrawn req: i_req pulse dropped during GAP -> no o_ack, o_busy falls after gap.
